qmca_event_ctrl: RTL and testbench

- Sequences the qmca channel selector: drives its 3-bit channel configuration, detects pulses on the selected ADC stream, and freezes the channel for the duration of each pulse so auto mode cannot hop channels mid-event.
- Tracks pulse peak and width, presents one event record per pulse on a valid/ready interface to the histogram/FIFO stage, then enforces a programmable hold-off.
- Sits between the configuration registers and the selector; the selector's outputs feed back into this block.

---
 rtl/qmca_event_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_qmca_event_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmca_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qmca_event_ctrl
// Purpose  : Drives the qmca channel selector, captures one pulse at a time
//            (peak, width), hands out event records and enforces hold-off.
//            Optional drop counter enabled by defining QMCA_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qmca_event_ctrl #(
    parameter int ADC_W   = 14,
    parameter int WIDTH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [2:0]         conf_channel,
    input  logic [ADC_W-1:0]   conf_threshold,
    input  logic [WIDTH_W-1:0] conf_holdoff,
    input  logic [1:0]         sel_channel,
    input  logic [ADC_W-1:0]   sel_adc_in,
    output logic [2:0]         mux_conf,
    output logic               busy,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_channel,
    output logic [ADC_W-1:0]   evt_peak,
    output logic [WIDTH_W-1:0] evt_width
`ifdef QMCA_DROP_CNT_EN
    ,
    input  logic               drop_clr,
    output logic [15:0]        drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_PEAK    = 3'd2,
        S_OUT     = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [2:0]         C_MUX_AUTO  = 3'b100;
    localparam logic [WIDTH_W-1:0] C_WIDTH_MAX = {WIDTH_W{1'b1}};

    state_t             state_q, state_d;
    logic [1:0]         lock_ch_q, lock_ch_d;
    logic [ADC_W-1:0]   peak_q, peak_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]         mux_conf_q, mux_conf_d;
    logic               busy_q, busy_d;
    logic               evt_valid_q, evt_valid_d;
    logic [1:0]         evt_channel_q, evt_channel_d;
    logic [ADC_W-1:0]   evt_peak_q, evt_peak_d;
    logic [WIDTH_W-1:0] evt_width_q, evt_width_d;
    logic               trig;

    assign trig = (sel_adc_in >= conf_threshold);

    always_comb begin
        state_d       = state_q;
        lock_ch_d     = lock_ch_q;
        peak_d        = peak_q;
        width_d       = width_q;
        hold_cnt_d    = hold_cnt_q;
        evt_valid_d   = evt_valid_q;
        evt_channel_d = evt_channel_q;
        evt_peak_d    = evt_peak_q;
        evt_width_d   = evt_width_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (trig) begin
                    state_d   = S_PEAK;
                    lock_ch_d = sel_channel;
                    peak_d    = sel_adc_in;
                    width_d   = WIDTH_W'(1);
                end
            end
            S_PEAK: begin
                if (trig) begin
                    if (sel_adc_in > peak_q) peak_d = sel_adc_in;
                    if (width_q != C_WIDTH_MAX) width_d = width_q + WIDTH_W'(1);
                end else begin
                    state_d       = S_OUT;
                    evt_valid_d   = 1'b1;
                    evt_channel_d = lock_ch_q;
                    evt_peak_d    = peak_q;
                    evt_width_d   = width_q;
                end
            end
            S_OUT: begin
                if (evt_valid_q && evt_ready) begin
                    evt_valid_d = 1'b0;
                    hold_cnt_d  = conf_holdoff;
                    state_d     = (conf_holdoff != '0) ? S_HOLDOFF : S_WAIT;
                end
            end
            S_HOLDOFF: begin
                // Counter starts at the hold-off value, so leaving on 1 gives
                // exactly that many dead cycles.
                if (hold_cnt_q <= WIDTH_W'(1)) begin
                    state_d    = S_WAIT;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - WIDTH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d     = S_IDLE;
            evt_valid_d = 1'b0;
        end

        // Auto mode is pinned to the locked channel for the life of a pulse.
        if (!conf_channel[2])
            mux_conf_d = {1'b0, conf_channel[1:0]};
        else if (state_d == S_PEAK || state_d == S_OUT)
            mux_conf_d = {1'b0, lock_ch_d};
        else
            mux_conf_d = C_MUX_AUTO;

        busy_d = (state_d == S_PEAK) || (state_d == S_OUT) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lock_ch_q     <= '0;
            peak_q        <= '0;
            width_q       <= '0;
            hold_cnt_q    <= '0;
            mux_conf_q    <= C_MUX_AUTO;
            busy_q        <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_channel_q <= '0;
            evt_peak_q    <= '0;
            evt_width_q   <= '0;
        end else begin
            state_q       <= state_d;
            lock_ch_q     <= lock_ch_d;
            peak_q        <= peak_d;
            width_q       <= width_d;
            hold_cnt_q    <= hold_cnt_d;
            mux_conf_q    <= mux_conf_d;
            busy_q        <= busy_d;
            evt_valid_q   <= evt_valid_d;
            evt_channel_q <= evt_channel_d;
            evt_peak_q    <= evt_peak_d;
            evt_width_q   <= evt_width_d;
        end
    end

    assign mux_conf    = mux_conf_q;
    assign busy        = busy_q;
    assign evt_valid   = evt_valid_q;
    assign evt_channel = evt_channel_q;
    assign evt_peak    = evt_peak_q;
    assign evt_width   = evt_width_q;

`ifdef QMCA_DROP_CNT_EN
    logic        trig_prev_q;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Counts trigger rising edges that arrive while a record is pending or
    // during dead time, i.e. pulses this block had to ignore.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr)
            drop_cnt_d = '0;
        else if ((state_q == S_OUT || state_q == S_HOLDOFF) && trig && !trig_prev_q
                 && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            trig_prev_q <= trig;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // No drop counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_qmca_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qmca_event_ctrl
// Purpose  : Self-checking bench for qmca_event_ctrl with a behavioural
//            selector and an index-arithmetic event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qmca_event_ctrl;

    localparam int ADC_W   = 14;
    localparam int WIDTH_W = 16;
    localparam int N_RND   = 400;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [2:0]         conf_channel;
    logic [ADC_W-1:0]   conf_threshold;
    logic [WIDTH_W-1:0] conf_holdoff;
    logic [1:0]         sel_channel;
    logic [ADC_W-1:0]   sel_adc_in;
    logic [2:0]         mux_conf;
    logic               busy;
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_channel;
    logic [ADC_W-1:0]   evt_peak;
    logic [WIDTH_W-1:0] evt_width;
`ifdef QMCA_DROP_CNT_EN
    logic               drop_clr;
    logic [15:0]        drop_cnt;
`endif

    logic [ADC_W-1:0] ch [4];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int cyc;
        int peak;
        int width;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  samp [N_RND];
    bit  rdy  [N_RND];

    qmca_event_ctrl #(.ADC_W(ADC_W), .WIDTH_W(WIDTH_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .conf_channel  (conf_channel),
        .conf_threshold(conf_threshold),
        .conf_holdoff  (conf_holdoff),
        .sel_channel   (sel_channel),
        .sel_adc_in    (sel_adc_in),
        .mux_conf      (mux_conf),
        .busy          (busy),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_channel   (evt_channel),
        .evt_peak      (evt_peak),
        .evt_width     (evt_width)
`ifdef QMCA_DROP_CNT_EN
        ,
        .drop_clr      (drop_clr),
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Selector model: fixed channel, or largest sample in auto mode.
    function automatic logic [1:0] pick_auto(input logic [ADC_W-1:0] a0, a1, a2, a3);
        logic [1:0]       best;
        logic [ADC_W-1:0] bv;
        best = 2'd0; bv = a0;
        if (a1 > bv) begin best = 2'd1; bv = a1; end
        if (a2 > bv) begin best = 2'd2; bv = a2; end
        if (a3 > bv) begin best = 2'd3; end
        return best;
    endfunction

    always_comb begin
        sel_channel = mux_conf[2] ? pick_auto(ch[0], ch[1], ch[2], ch[3]) : mux_conf[1:0];
        sel_adc_in  = ch[sel_channel];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ch;
        for (int i = 0; i < 4; i++) ch[i] = '0;
    endtask

    // Leaves the DUT in WAIT with the given configuration at the start of cycle 0.
    task automatic prep(input int cfg, input int thr, input int h);
        enable         = 1'b0;
        evt_ready      = 1'b1;
        clear_ch();
        conf_channel   = 3'(cfg);
        conf_threshold = ADC_W'(thr);
        conf_holdoff   = WIDTH_W'(h);
`ifdef QMCA_DROP_CNT_EN
        drop_clr = 1'b1;
`endif
        tick();
`ifdef QMCA_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; evt_ready = 1'b0; clear_ch();
        conf_channel = 3'd0; conf_threshold = '0; conf_holdoff = '0;
`ifdef QMCA_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        tick(); tick();
        n_checks++;
        if ({mux_conf, busy, evt_valid} !== {3'b100, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: mux/busy/valid=%b required 10000", {mux_conf, busy, evt_valid});
        else n_pass++;
        n_checks++;
        if ({evt_channel, evt_peak, evt_width} !== '0)
            $display("FAIL reset_evt: ch=%0d peak=%0d width=%0d required 0/0/0", evt_channel, evt_peak, evt_width);
        else n_pass++;
`ifdef QMCA_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd0) $display("FAIL reset_drop: %0d required 0", drop_cnt);
        else n_pass++;
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_channel;
        int vals [11] = '{50, 120, 300, 200, 90, 0, 0, 0, 0, 0, 0};
        int nx = 0;
        int mux_bad = 0;
        prep(2, 100, 3);
        for (int k = 0; k < 11; k++) begin
            ch[2] = ADC_W'(vals[k]);
            ch[0] = ADC_W'($urandom_range(0, 16383));
            ch[3] = ADC_W'($urandom_range(0, 16383));
            if (mux_conf !== 3'b010) mux_bad++;
            if (evt_valid && evt_ready) begin
                nx++;
                n_checks++;
                if (k != 5 || evt_channel !== 2'd2 || evt_peak !== 14'd300 || evt_width !== 16'd3)
                    $display("FAIL fixed_event: cyc=%0d ch=%0d peak=%0d width=%0d required cyc5 2/300/3",
                             k, evt_channel, evt_peak, evt_width);
                else n_pass++;
            end
            if (k == 8) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL fixed_busy_holdoff: busy=%b required 1", busy);
                else n_pass++;
            end
            if (k == 10) begin
                n_checks++;
                if (busy !== 1'b0) $display("FAIL fixed_busy_end: busy=%b required 0", busy);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (nx != 1 || mux_bad != 0)
            $display("FAIL fixed_count: transfers=%0d mux_errors=%0d required 1/0", nx, mux_bad);
        else n_pass++;
    endtask

    task automatic test_auto_lock;
        int c1 [13] = '{0, 500, 600, 700, 400, 50, 0, 0, 0, 0, 0, 0, 0};
        int c3 [13] = '{0, 0,   900, 900, 900, 0,  0, 0, 0, 0, 0, 0, 0};
        int nx = 0;
        int lock_bad = 0;
        int free_bad = 0;
        prep(4, 100, 4);
        for (int k = 0; k < 13; k++) begin
            ch[1] = ADC_W'(c1[k]);
            ch[3] = ADC_W'(c3[k]);
            if (k == 3) conf_channel = 3'd7;
            if (k >= 2 && k <= 6 && mux_conf !== 3'b001) lock_bad++;
            if (k >= 7 && k <= 10 && mux_conf !== 3'b100) free_bad++;
            if (evt_valid && evt_ready) begin
                nx++;
                n_checks++;
                if (k != 6 || evt_channel !== 2'd1 || evt_peak !== 14'd700 || evt_width !== 16'd4)
                    $display("FAIL auto_event: cyc=%0d ch=%0d peak=%0d width=%0d required cyc6 1/700/4",
                             k, evt_channel, evt_peak, evt_width);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (lock_bad != 0) $display("FAIL auto_mux_locked: %0d cycles not 001 required 0", lock_bad);
        else n_pass++;
        n_checks++;
        if (free_bad != 0) $display("FAIL auto_mux_holdoff: %0d cycles not 100 required 0", free_bad);
        else n_pass++;
        n_checks++;
        if (nx != 1) $display("FAIL auto_count: transfers=%0d required 1", nx);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int nx = 0;
        int unstable = 0;
        prep(0, 100, 0);
        evt_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ch[0] = (k == 1) ? 14'd200 : (k == 2) ? 14'd250 : 14'd0;
            evt_ready = (k >= 14);
            if (k >= 4 && k <= 13 &&
                {evt_valid, evt_channel, evt_peak, evt_width} !== {1'b1, 2'd0, 14'd250, 16'd2})
                unstable++;
            if (evt_valid && evt_ready) begin
                nx++;
                n_checks++;
                if (k != 14) $display("FAIL bp_xfer_cycle: cyc=%0d required 14", k);
                else n_pass++;
            end
            if (k == 15) begin
                n_checks++;
                if ({evt_valid, busy} !== 2'b00) $display("FAIL bp_after: valid/busy=%b required 00", {evt_valid, busy});
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (unstable != 0 || nx != 1)
            $display("FAIL bp_hold: unstable=%0d transfers=%0d required 0/1", unstable, nx);
        else n_pass++;
    endtask

    task automatic test_holdoff;
        int nx = 0;
        int last_peak = -1;
        int last_width = -1;
        int last_cyc = -1;
        prep(0, 100, 5);
        for (int k = 0; k < 14; k++) begin
            ch[0] = (k == 1) ? 14'd200 : (k == 5) ? 14'd300 : (k == 9) ? 14'd400 : 14'd0;
            if (evt_valid && evt_ready) begin
                nx++;
                last_cyc = k; last_peak = int'(evt_peak); last_width = int'(evt_width);
            end
            tick();
        end
        n_checks++;
        if (nx != 2 || last_cyc != 11 || last_peak != 400 || last_width != 1)
            $display("FAIL holdoff_events: n=%0d cyc=%0d peak=%0d width=%0d required 2 11/400/1",
                     nx, last_cyc, last_peak, last_width);
        else n_pass++;
`ifdef QMCA_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) $display("FAIL holdoff_drop_cnt: %0d required 1", drop_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_thresholds;
        bit any_valid = 1'b0;
        prep(0, 150, 0);
        ch[0] = 14'd0;   tick();
        ch[0] = 14'd150; tick();
        ch[0] = 14'd149; tick();
        n_checks++;
        if ({evt_valid, evt_peak, evt_width} !== {1'b1, 14'd150, 16'd1})
            $display("FAIL thr_equal: valid=%b peak=%0d width=%0d required 1/150/1", evt_valid, evt_peak, evt_width);
        else n_pass++;

        prep(0, 10, 0);
        evt_ready = 1'b0;
        ch[0] = 14'd20;
        for (int k = 0; k < 70000; k++) tick();
        n_checks++;
        if ({busy, evt_valid} !== 2'b10) $display("FAIL sat_inflight: busy/valid=%b required 10", {busy, evt_valid});
        else n_pass++;
        ch[0] = 14'd0;
        tick();
        n_checks++;
        if ({evt_valid, evt_peak, evt_width} !== {1'b1, 14'd20, 16'hFFFF})
            $display("FAIL sat_width: valid=%b peak=%0d width=%0d required 1/20/65535", evt_valid, evt_peak, evt_width);
        else n_pass++;

        prep(4, 0, 0);
        for (int k = 0; k < 300; k++) begin
            ch[k % 4] = ADC_W'($urandom_range(0, 16383));
            if (evt_valid) any_valid = 1'b1;
            tick();
        end
        n_checks++;
        if (any_valid || busy !== 1'b1) $display("FAIL thr_zero_run: any_valid=%b busy=%b required 0/1", any_valid, busy);
        else n_pass++;
        enable = 1'b0;
        tick();
        n_checks++;
        if ({busy, evt_valid, mux_conf} !== {2'b00, 3'b100})
            $display("FAIL thr_zero_disable: busy/valid/mux=%b required 00100", {busy, evt_valid, mux_conf});
        else n_pass++;
    endtask

    task automatic test_reset_mid_out;
        prep(0, 100, 0);
        evt_ready = 1'b0;
        ch[0] = 14'd0;   tick();
        ch[0] = 14'd200; tick();
        ch[0] = 14'd0;   tick();
        n_checks++;
        if (evt_valid !== 1'b1) $display("FAIL rst_pre_valid: valid=%b required 1", evt_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({evt_valid, busy, mux_conf, evt_peak} !== {2'b00, 3'b100, 14'd0})
            $display("FAIL rst_async: valid=%b busy=%b mux=%b peak=%0d required 0/0/100/0",
                     evt_valid, busy, mux_conf, evt_peak);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0; enable = 1'b1; conf_channel = 3'd6; clear_ch();
        tick();
        n_checks++;
        if ({busy, mux_conf} !== 4'b0100) $display("FAIL rst_wait: busy/mux=%b required 0100", {busy, mux_conf});
        else n_pass++;
        ch[2] = 14'd300;
        tick();
        n_checks++;
        if ({busy, mux_conf} !== 4'b1010) $display("FAIL rst_peak: busy/mux=%b required 1010", {busy, mux_conf});
        else n_pass++;
    endtask

    // Expected transfers derived from the sample/ready streams alone.
    task automatic model_events(input int thr, input int h);
        int t = 0;
        exp_q.delete();
        while (t < N_RND) begin
            int i, j, k, pk;
            i = t;
            while (i < N_RND && samp[i] < thr) i++;
            if (i >= N_RND) break;
            pk = samp[i];
            j = i + 1;
            while (j < N_RND && samp[j] >= thr) begin
                if (samp[j] > pk) pk = samp[j];
                j++;
            end
            if (j >= N_RND) break;
            k = j + 1;
            while (k < N_RND && !rdy[k]) k++;
            if (k >= N_RND) break;
            exp_q.push_back('{cyc: k, peak: pk, width: j - i});
            t = k + 1 + h;
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            int chn = $urandom_range(0, 3);
            int thr = $urandom_range(50, 2000);
            int h   = $urandom_range(0, 6);
            int k   = 0;
            int bad = 0;
            while (k < N_RND) begin
                bit hi = $urandom_range(0, 1) == 1;
                int len = $urandom_range(1, 8);
                for (int n = 0; n < len && k < N_RND; n++) begin
                    samp[k] = hi ? thr + $urandom_range(0, 3000) : $urandom_range(0, thr - 1);
                    rdy[k]  = $urandom_range(0, 9) < 7;
                    k++;
                end
            end
            model_events(thr, h);
            obs_q.delete();
            prep(chn, thr, h);
            for (int c = 0; c < N_RND; c++) begin
                for (int q = 0; q < 4; q++)
                    ch[q] = (q == chn) ? ADC_W'(samp[c]) : ADC_W'($urandom_range(0, 16383));
                evt_ready = rdy[c];
                if (evt_valid && evt_ready) begin
                    obs_q.push_back('{cyc: c, peak: int'(evt_peak), width: int'(evt_width)});
                    if (evt_channel !== 2'(chn)) bad++;
                end
                tick();
            end
            n_checks++;
            if (obs_q.size() != exp_q.size() || bad != 0)
                $display("FAIL rnd_count r%0d: events=%0d chan_errors=%0d required %0d/0",
                         r, obs_q.size(), bad, exp_q.size());
            else n_pass++;
            for (int e = 0; e < obs_q.size() && e < exp_q.size(); e++) begin
                n_checks++;
                if (obs_q[e] != exp_q[e])
                    $display("FAIL rnd_event r%0d #%0d: cyc=%0d peak=%0d width=%0d required %0d/%0d/%0d",
                             r, e, obs_q[e].cyc, obs_q[e].peak, obs_q[e].width,
                             exp_q[e].cyc, exp_q[e].peak, exp_q[e].width);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_channel();
        test_auto_lock();
        test_backpressure();
        test_holdoff();
        test_thresholds();
        test_reset_mid_out();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
